// File: rtl/aes_round_engine.sv
// aes_round_engine
// Iterative AES round engine. One shared datapath runs either the cipher or the
// inverse cipher, chosen per block. Round keys are fetched one per cycle from an
// external key-schedule store whose read latency is KEY_LAT cycles.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           input block handshake
//   in_data, in_decrypt,        block, mode (1 = decipher), round count Nr
//   in_rounds, in_tag           and opaque tag, all sampled at the handshake
//   key_rd_en, key_round_no     round-key read strobe and requested round index
//   round_key                   key data, valid KEY_LAT cycles after its request
//   out_valid/out_ready         result handshake (backpressured)
//   out_data, out_tag, out_err  result, its tag, and illegal-Nr flag
//   busy                        engine is not idle
// Byte order: out_data[7:0] / in_data[7:0] is state byte 0 (column 0, row 0),
// bytes run column-major.
module aes_round_engine #(
  parameter int KEY_LAT = 1,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_decrypt,
  input  logic [3:0]       in_rounds,
  input  logic [TAG_W-1:0] in_tag,
  output logic             key_rd_en,
  output logic [3:0]       key_round_no,
  input  logic [127:0]     round_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // GF(2^8) helpers
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xt(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Multiplicative inverse as x^254; 254 = 2+4+...+128, so accumulate the
  // successive squares. Maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  // S-box and inverse S-box share the inverter; only the affine step differs.
  function automatic logic [7:0] byte_sub(input logic [7:0] x, input logic inv);
    logic [7:0] y;
    if (!inv) begin
      y = ginv(x);
      y = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    end else begin
      y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      y = ginv(y);
    end
    return y;
  endfunction

  // Row r rotates left by r (forward) or right by r (inverse).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    int dst;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c + r) % 4) + r;
        dst = 4 * c + r;
        if (!inv) o[dst*8 +: 8] = s[src*8 +: 8];
        else      o[src*8 +: 8] = s[dst*8 +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) a[i] = col[i*8 +: 8];
    for (int i = 0; i < 4; i++) begin
      if (!inv)
        r[i*8 +: 8] = xt(a[i]) ^ xt(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      else
        r[i*8 +: 8] = gmul(a[i], 8'h0e) ^ gmul(a[(i+1)%4], 8'h0b) ^
                      gmul(a[(i+2)%4], 8'h0d) ^ gmul(a[(i+3)%4], 8'h09);
    end
    return r;
  endfunction

  state_t             state_q;
  logic               in_ready_q, out_valid_q, out_err_q, busy_q;
  logic               key_rd_en_q;
  logic [3:0]         key_round_no_q, req_cnt_q, apply_cnt_q, nr_q;
  logic [127:0]       s_q;
  logic [TAG_W-1:0]   tag_q;
  logic               dec_q;
  logic [KEY_LAT-1:0] kv_q;
  logic               key_valid;
  logic               nr_legal;

  logic [127:0] sub_in, sub_out, enc_sr, dec_ark, mix_in, mix_out, round_d;

  // Decrypt applies InvShiftRows before the S-boxes, encrypt after, so one
  // bank of 16 S-boxes serves both directions.
  assign sub_in  = dec_q ? shift_rows(s_q, 1'b1) : s_q;
  assign enc_sr  = shift_rows(sub_out, 1'b0);
  assign dec_ark = sub_out ^ round_key;
  assign mix_in  = dec_q ? dec_ark : enc_sr;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox
      assign sub_out[gi*8 +: 8] = byte_sub(sub_in[gi*8 +: 8], dec_q);
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign mix_out[gi*32 +: 32] = mix_col(mix_in[gi*32 +: 32], dec_q);
    end
  endgenerate

  always_comb begin
    round_d = s_q ^ round_key;
    if (apply_cnt_q != 4'd0) begin
      if (apply_cnt_q == nr_q) round_d = dec_q ? dec_ark : (enc_sr ^ round_key);
      else                     round_d = dec_q ? mix_out : (mix_out ^ round_key);
    end
  end

  assign nr_legal  = (in_rounds == 4'd10) || (in_rounds == 4'd12) || (in_rounds == 4'd14);
  assign key_valid = kv_q[KEY_LAT-1];

  // Tracks which cycles carry a requested key; clearing it on reset drops
  // any responses still in flight from the key store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kv_q <= '0;
    end else begin
      kv_q[0] <= key_rd_en_q;
      for (int i = 1; i < KEY_LAT; i++) kv_q[i] <= kv_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      key_rd_en_q    <= 1'b0;
      key_round_no_q <= '0;
      req_cnt_q      <= '0;
      apply_cnt_q    <= '0;
      s_q            <= '0;
      tag_q          <= '0;
      dec_q          <= 1'b0;
      nr_q           <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            tag_q      <= in_tag;
            dec_q      <= in_decrypt;
            nr_q       <= in_rounds;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (nr_legal) begin
              s_q            <= in_data;
              state_q        <= RUN;
              out_err_q      <= 1'b0;
              key_rd_en_q    <= 1'b1;
              key_round_no_q <= in_decrypt ? in_rounds : 4'd0;
              req_cnt_q      <= '0;
              apply_cnt_q    <= '0;
            end else begin
              s_q         <= '0;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (key_rd_en_q) begin
            if (req_cnt_q == nr_q) begin
              key_rd_en_q <= 1'b0;
            end else begin
              req_cnt_q      <= req_cnt_q + 4'd1;
              key_round_no_q <= dec_q ? key_round_no_q - 4'd1 : key_round_no_q + 4'd1;
            end
          end
          if (key_valid) begin
            s_q         <= round_d;
            apply_cnt_q <= apply_cnt_q + 4'd1;
            if (apply_cnt_q == nr_q) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_err      = out_err_q;
  assign busy         = busy_q;
  assign key_rd_en    = key_rd_en_q;
  assign key_round_no = key_round_no_q;
  assign out_data     = s_q;
  assign out_tag      = tag_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: two engines (KEY_LAT=1 and KEY_LAT=3) each fed
// by a small key-store model; FIPS-197 known-answer vectors plus handshake,
// illegal-Nr and asynchronous-reset sequences.
module tb_aes_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid [2];
  logic         in_ready [2];
  logic [127:0] in_data [2];
  logic         in_decrypt [2];
  logic [3:0]   in_rounds [2];
  logic [7:0]   in_tag [2];
  logic         key_rd_en [2];
  logic [3:0]   key_round_no [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_data [2];
  logic [7:0]   out_tag [2];
  logic         out_err [2];
  logic         busy [2];

  logic [127:0] rk_tab [2][16];
  logic [7:0]   sbox [256];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           u;
    logic         dec;
    logic [3:0]   nr;
    logic [127:0] din;
    logic [127:0] dexp;
    logic [7:0]   tag;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   tag;
    logic         err;
  } exp_t;

  exp_t sb_q [$];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_u
      localparam int KL = (gi == 0) ? 1 : 3;
      logic [127:0] kp [KL];
      aes_round_engine #(.KEY_LAT(KL), .TAG_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[gi]), .in_ready(in_ready[gi]), .in_data(in_data[gi]),
        .in_decrypt(in_decrypt[gi]), .in_rounds(in_rounds[gi]), .in_tag(in_tag[gi]),
        .key_rd_en(key_rd_en[gi]), .key_round_no(key_round_no[gi]), .round_key(kp[KL-1]),
        .out_valid(out_valid[gi]), .out_ready(out_ready[gi]), .out_data(out_data[gi]),
        .out_tag(out_tag[gi]), .out_err(out_err[gi]), .busy(busy[gi])
      );
      // Key store: KL-cycle read pipeline of the expanded schedule
      always @(posedge clk) begin
        kp[0] <= key_rd_en[gi] ? rk_tab[gi][key_round_no[gi]] : 128'h0;
        for (int i = 1; i < KL; i++) kp[i] <= kp[i-1];
      end
    end
  endgenerate

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS text order (first byte in the MSBs) to engine order (byte 0 in [7:0])
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = h[(15-b)*8 +: 8];
    return r;
  endfunction

  function automatic logic legal(input logic [3:0] nr);
    return (nr == 4'd10) || (nr == 4'd12) || (nr == 4'd14);
  endfunction

  // Key bytes are 00,01,02,... for every test key length
  task automatic expand(input int u, input int nr);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] k;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          k[(4*c+row)*8 +: 8] = w[4*r+c][(3-row)*8 +: 8];
      rk_tab[u][r] = k;
    end
  endtask

  function automatic vec_t mk(input int u, input logic dec, input logic [3:0] nr,
                              input logic [127:0] din, input logic [127:0] dexp,
                              input logic [7:0] tag);
    vec_t v;
    v.u = u; v.dec = dec; v.nr = nr; v.din = fips(din); v.dexp = fips(dexp); v.tag = tag;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    if (legal(v.nr)) expand(v.u, int'(v.nr));
    e.data = legal(v.nr) ? v.dexp : 128'h0;
    e.tag  = v.tag;
    e.err  = !legal(v.nr);
    sb_q.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    in_valid[v.u]   = 1'b1;
    in_data[v.u]    = v.din;
    in_decrypt[v.u] = v.dec;
    in_rounds[v.u]  = v.nr;
    in_tag[v.u]     = v.tag;
    check("in_ready_idle", 128'(in_ready[v.u]), 128'd1);
  endtask

  // Called in the accept cycle; returns at the negedge of the first out_valid cycle
  task automatic collect(input vec_t v);
    int cyc, nreq, kl, lat_exp;
    logic ok_seq;
    logic [3:0] want;
    exp_t e;
    kl = (v.u == 0) ? 1 : 3;
    @(negedge clk);
    in_valid[v.u] = 1'b0;
    cyc = 1; nreq = 0; ok_seq = 1'b1;
    check("busy_after_accept", 128'(busy[v.u]), 128'd1);
    check("in_ready_after_accept", 128'(in_ready[v.u]), 128'd0);
    while (!out_valid[v.u] && cyc < 200) begin
      if (key_rd_en[v.u]) begin
        want = v.dec ? v.nr - 4'(nreq) : 4'(nreq);
        if (key_round_no[v.u] !== want) ok_seq = 1'b0;
        nreq++;
      end
      @(negedge clk);
      cyc++;
    end
    lat_exp = legal(v.nr) ? int'(v.nr) + 2 + kl : 1;
    check("latency", 128'(cyc), 128'(lat_exp));
    check("key_seq", 128'(ok_seq), 128'd1);
    check("key_count", 128'(nreq), legal(v.nr) ? 128'(int'(v.nr) + 1) : 128'd0);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 128'd1, 128'd0);
    end else begin
      e = sb_q.pop_front();
      check("out_data", out_data[v.u], e.data);
      check("out_tag", 128'(out_tag[v.u]), 128'(e.tag));
      check("out_err", 128'(out_err[v.u]), 128'(e.err));
    end
    $display("block u=%0d dec=%0d nr=%0d tag=%h out=%h err=%0d lat=%0d reqs=%0d",
             v.u, v.dec, v.nr, out_tag[v.u], out_data[v.u], out_err[v.u], cyc, nreq);
  endtask

  task automatic run(input vec_t v);
    push_exp(v);
    drive(v);
    collect(v);
    @(negedge clk);
    check("out_valid_after_hs", 128'(out_valid[v.u]), 128'd0);
    check("in_ready_after_hs", 128'(in_ready[v.u]), 128'd1);
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    vec_t vt [9];
    vec_t bad;
    logic stable, quiet;

    vt[0] = mk(0, 1'b0, 4'd10, PT,   C128, 8'h11);
    vt[1] = mk(0, 1'b1, 4'd14, C256, PT,   8'hA5);
    vt[2] = mk(0, 1'b0, 4'd14, PT,   C256, 8'h22);
    vt[3] = mk(0, 1'b1, 4'd10, C128, PT,   8'h33);
    vt[4] = mk(0, 1'b0, 4'd12, PT,   C192, 8'h44);
    vt[5] = mk(0, 1'b1, 4'd12, C192, PT,   8'h55);
    vt[6] = mk(1, 1'b0, 4'd12, PT,   C192, 8'h66);
    vt[7] = mk(1, 1'b1, 4'd10, C128, PT,   8'h77);
    vt[8] = mk(1, 1'b0, 4'd14, PT,   C256, 8'h88);
    bad   = mk(0, 1'b0, 4'd11, PT,   C128, 8'h3C);

    build_sbox();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_data[u] = '0; in_decrypt[u] = 1'b0;
      in_rounds[u] = '0; in_tag[u] = '0; out_ready[u] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", 128'(in_ready[u]), 128'd1);
      check("rst_out_valid", 128'(out_valid[u]), 128'd0);
      check("rst_key_rd_en", 128'(key_rd_en[u]), 128'd0);
      check("rst_key_round_no", 128'(key_round_no[u]), 128'd0);
      check("rst_busy", 128'(busy[u]), 128'd0);
      check("rst_out_err", 128'(out_err[u]), 128'd0);
      check("rst_out_data", out_data[u], 128'd0);
      check("rst_out_tag", 128'(out_tag[u]), 128'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run(vt[i]);

    // Backpressure: hold DONE for 20 cycles with a second block waiting
    out_ready[0] = 1'b0;
    push_exp(vt[0]);
    drive(vt[0]);
    collect(vt[0]);
    in_valid[0] = 1'b1; in_data[0] = vt[3].din; in_decrypt[0] = vt[3].dec;
    in_rounds[0] = vt[3].nr; in_tag[0] = vt[3].tag;
    stable = 1'b1; quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || out_data[0] !== vt[0].dexp || out_tag[0] !== vt[0].tag)
        stable = 1'b0;
      if (key_rd_en[0] !== 1'b0 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) quiet = 1'b0;
    end
    check("bp_outputs_stable", 128'(stable), 128'd1);
    check("bp_no_activity", 128'(quiet), 128'd1);
    out_ready[0] = 1'b1;
    push_exp(vt[3]);
    @(negedge clk);
    check("bp_idle_out_valid", 128'(out_valid[0]), 128'd0);
    check("bp_idle_in_ready", 128'(in_ready[0]), 128'd1);
    check("bp_not_yet_busy", 128'(busy[0]), 128'd0);
    collect(vt[3]);
    @(negedge clk);

    // Illegal round count, then a normal block
    run(bad);
    run(vt[0]);

    // Asynchronous reset in RUN cycle 5
    push_exp(vt[0]);
    drive(vt[0]);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_key_rd_en", 128'(key_rd_en[0]), 128'd1);
    check("pre_rst_busy", 128'(busy[0]), 128'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_key_rd_en", 128'(key_rd_en[0]), 128'd0);
    check("arst_busy", 128'(busy[0]), 128'd0);
    check("arst_out_valid", 128'(out_valid[0]), 128'd0);
    check("arst_key_round_no", 128'(key_round_no[0]), 128'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst_in_ready", 128'(in_ready[0]), 128'd1);
    run(vt[0]);
    run(vt[6]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
